// File: rtl/led_share_arbiter.sv
// Round-robin LED bank arbiter with minimum hold time and per-requester blinking.
// Optional IDLE_HEARTBEAT_EN: a walking one-hot on the LEDs while idle.
module led_share_arbiter #(
    parameter int LED         = 4,
    parameter int NREQ        = 4,
    parameter int TICK_CYCLES = 100000,
    parameter int HOLD_TICKS  = 500,
    parameter int BLINK_TICKS = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LED-1:0]   pattern,
    input  logic [NREQ-1:0]       blink,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [LED-1:0]        led
);

    localparam int IW = $clog2(NREQ);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
`ifdef IDLE_HEARTBEAT_EN
    localparam logic [LED-1:0] IDLE_LED = LED'(1);
`else
    localparam logic [LED-1:0] IDLE_LED = '0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_OWN} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]     last_q, last_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              phase_q, phase_d;
    logic [LED-1:0]    led_q, led_d;

    logic              tick, toggle, any_found, take;
    logic [IW-1:0]     cand, any_idx;
    logic [LED-1:0]    show_any, show_own;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NREQ - 1);
            hold_q  <= '0;
            presc_q <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b1;
            led_q   <= IDLE_LED;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            presc_q <= presc_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign tick   = (presc_q == PW'(TICK_CYCLES - 1));
    assign toggle = tick && (bcnt_q == BW'(BLINK_TICKS - 1));

    // Search starts just after the last owner; hitting the owner itself last means no one else waits.
    always_comb begin
        any_found = 1'b0;
        any_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= 32'(NREQ); k++) begin
            cand = IW'((32'(last_q) + k) % 32'(NREQ));
            if (!any_found && req[cand]) begin
                any_found = 1'b1;
                any_idx   = cand;
            end
        end
    end

    always_comb begin
        show_any = pattern[32'(any_idx)*LED +: LED];
        if (blink[any_idx] && !phase_q)
            show_any = '0;
        show_own = pattern[32'(last_q)*LED +: LED];
        if (blink[last_q] && !phase_q)
            show_own = '0;
    end

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (toggle) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else if (tick) begin
            bcnt_d  = bcnt_q + BW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        hold_d  = hold_q;
        led_d   = led_q;
        take    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_found)
                    take = 1'b1;
            end
            S_HOLD: begin
                if (hold_q == '0)
                    state_d = S_OWN;
                else if (tick)
                    hold_d = hold_q - HW'(1);
            end
            S_OWN: begin
                if (any_found && (any_idx != last_q)) begin
                    take = 1'b1;
                end else if (!req[last_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    led_d   = IDLE_LED;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take) begin
            state_d = S_HOLD;
            grant_d = NREQ'(1) << any_idx;
            last_d  = any_idx;
            hold_d  = HW'(HOLD_TICKS);
            led_d   = show_any;
        end else if (state_q != S_IDLE && state_d != S_IDLE) begin
            if (req[last_q])
                led_d = show_own;
        end else if (state_q == S_IDLE) begin
`ifdef IDLE_HEARTBEAT_EN
            if (toggle)
                led_d = {led_q[LED-2:0], led_q[LED-1]};
`else
            led_d = '0;
`endif
        end
    end

    always_comb begin
        grant = grant_q;
        busy  = (state_q != S_IDLE);
        led   = led_q;
    end

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed self-checking bench for led_share_arbiter (TICK=4, HOLD=3, BLINK=2).
// Honours IDLE_HEARTBEAT_EN for the expected idle LED values.
module tb_led_share_arbiter;

`ifdef IDLE_HEARTBEAT_EN
    localparam logic [3:0] IDLE_LED = 4'b0001;
    localparam bit         HB       = 1'b1;
`else
    localparam logic [3:0] IDLE_LED = 4'b0000;
    localparam bit         HB       = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] pattern = '0;
    logic [3:0]  blink = '0;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  led;

    int checks = 0;
    int errors = 0;
    int e = 0;

    always #5 clk = ~clk;

    led_share_arbiter #(
        .LED(4), .NREQ(4), .TICK_CYCLES(4), .HOLD_TICKS(3), .BLINK_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .pattern(pattern), .blink(blink),
        .grant(grant), .busy(busy), .led(led)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic goto(input int t);
        while (e < t) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    // Reset takes effect between edges; inputs are applied as reset releases.
    task automatic do_reset(input logic [3:0] r, input logic [15:0] p, input logic [3:0] b);
        rst = 1'b1;
        #1;
        chk("rst_grant", 16'(grant), 16'(4'b0000));
        chk("rst_busy",  16'(busy),  16'(1'b0));
        chk("rst_led",   16'(led),   16'(IDLE_LED));
        @(posedge clk);
        #1;
        req = r;
        pattern = p;
        blink = b;
        rst = 1'b0;
        e = 0;
    endtask

    initial begin
        // 1: async reset between edges
        #3;
        do_reset(4'b0100, 16'h0A00, 4'b0000);

        // 2: single requester
        goto(1);
        chk("t2_grant", 16'(grant), 16'(4'b0100));
        chk("t2_busy",  16'(busy),  16'(1'b1));
        chk("t2_led",   16'(led),   16'(4'b1010));
        goto(13);
        chk("t2_own_grant", 16'(grant), 16'(4'b0100));
        pattern = 16'h0A05;
        blink = 4'b0001;
        goto(14);
        chk("t2_other_pat", 16'(led), 16'(4'b1010));
        pattern = 16'h0505;
        goto(15);
        chk("t2_own_pat", 16'(led), 16'(4'b0101));

        // 3: two requesters alternate without idle gap
        do_reset(4'b0011, 16'h0021, 4'b0000);
        for (int t = 1; t <= 26; t++) begin
            goto(t);
            chk("t3_onehot", 16'($onehot(grant)), 16'(1'b1));
            chk("t3_busy", 16'(busy), 16'(|grant));
            if (t == 1)  chk("t3_first",  16'(grant), 16'(4'b0001));
            if (t == 13) chk("t3_hold0",  16'(grant), 16'(4'b0001));
            if (t == 14) chk("t3_sw1",    16'(grant), 16'(4'b0010));
            if (t == 14) chk("t3_sw1_led", 16'(led),  16'(4'b0010));
            if (t == 25) chk("t3_hold1",  16'(grant), 16'(4'b0010));
            if (t == 26) chk("t3_sw2",    16'(grant), 16'(4'b0001));
            if (t == 26) chk("t3_sw2_led", 16'(led),  16'(4'b0001));
        end

        // 4: owner drops request during hold
        do_reset(4'b0001, 16'h0006, 4'b0000);
        goto(1);
        chk("t4_grant", 16'(grant), 16'(4'b0001));
        chk("t4_led",   16'(led),   16'(4'b0110));
        goto(2);
        req = 4'b0000;
        pattern = 16'h000F;
        for (int t = 3; t <= 13; t++) begin
            goto(t);
            chk("t4_frozen", 16'(led),   16'(4'b0110));
            chk("t4_held",   16'(grant), 16'(4'b0001));
        end
        goto(14);
        chk("t4_idle_grant", 16'(grant), 16'(4'b0000));
        chk("t4_idle_busy",  16'(busy),  16'(1'b0));
        chk("t4_idle_led",   16'(led),   16'(IDLE_LED));

        // 5: blinking owner, then idle heartbeat
        do_reset(4'b0010, 16'h00F0, 4'b0010);
        goto(1);  chk("t5_b1",  16'(led), 16'(4'b1111));
        goto(8);  chk("t5_b8",  16'(led), 16'(4'b1111));
        goto(9);  chk("t5_b9",  16'(led), 16'(4'b0000));
        goto(16); chk("t5_b16", 16'(led), 16'(4'b0000));
        goto(17); chk("t5_b17", 16'(led), 16'(4'b1111));
        goto(24); chk("t5_b24", 16'(led), 16'(4'b1111));
        goto(25); chk("t5_b25", 16'(led), 16'(4'b0000));
        goto(32); chk("t5_b32", 16'(led), 16'(4'b0000));
        req = 4'b0000;
        goto(33);
        chk("t5_idle_grant", 16'(grant), 16'(4'b0000));
        chk("t5_idle_led",   16'(led),   16'(IDLE_LED));
        goto(39); chk("t5_hb39", 16'(led), 16'(IDLE_LED));
        goto(40); chk("t5_hb40", 16'(led), 16'(HB ? 4'b0010 : 4'b0000));
        goto(48); chk("t5_hb48", 16'(led), 16'(HB ? 4'b0100 : 4'b0000));
        goto(56); chk("t5_hb56", 16'(led), 16'(HB ? 4'b1000 : 4'b0000));
        goto(64); chk("t5_hb64", 16'(led), 16'(IDLE_LED));

        // 6: reset mid-hold with request still high
        do_reset(4'b1000, 16'h9000, 4'b0000);
        goto(1);
        chk("t6_grant", 16'(grant), 16'(4'b1000));
        chk("t6_led",   16'(led),   16'(4'b1001));
        goto(5);
        chk("t6_busy", 16'(busy), 16'(1'b1));
        do_reset(4'b1000, 16'h9003, 4'b0000);
        goto(1);
        chk("t6_regrant", 16'(grant), 16'(4'b1000));
        req = 4'b1001;
        goto(13);
        chk("t6_hold_full", 16'(grant), 16'(4'b1000));
        goto(14);
        chk("t6_next",     16'(grant), 16'(4'b0001));
        chk("t6_next_led", 16'(led),   16'(4'b0011));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
